// File: rtl/trap_ctrl_pkg.sv
// Shared encodings for the commit-stage trap controller: privilege levels,
// FSM states, CSR addresses and mstatus field positions.
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REDIRECT = 2'b01,
        ST_WFI      = 2'b10
    } state_e;

    localparam logic [11:0] CSR_SSTATUS = 12'h100;
    localparam logic [11:0] CSR_STVEC   = 12'h105;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEDELEG = 12'h302;
    localparam logic [11:0] CSR_MIDELEG = 12'h303;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_SIE    = 1;
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_SPIE   = 5;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_SPP    = 8;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // sstatus exposes only SIE, SPIE and SPP of mstatus.
    localparam logic [63:0] SSTATUS_MASK = 64'h0000_0000_0000_0122;

    // The reserved encoding 2'b10 is not a legal previous privilege; fold it to U.
    function automatic priv_e legal_mpp(input logic [1:0] v);
        return (v == 2'b10) ? PRIV_U : priv_e'(v);
    endfunction

endpackage

// File: rtl/trap_ctrl_target_calc.sv
// Combinational redirect-target computation: trap delegation, direct or
// vectored trap vector, and the xRET return addresses.
module trap_target_calc
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN                  = 64,
    parameter int PC_WIDTH              = 39,
    parameter int EXCEPTION_CAUSE_WIDTH = 4
) (
    input  priv_e                            i_priv,
    input  logic                             i_interrupt,
    input  logic [EXCEPTION_CAUSE_WIDTH-1:0] i_cause,
    input  logic [XLEN-1:0]                  i_medeleg,
    input  logic [XLEN-1:0]                  i_mideleg,
    input  logic [PC_WIDTH-1:2]              i_mtvec_base,
    input  logic                             i_mtvec_mode,
    input  logic [PC_WIDTH-1:2]              i_stvec_base,
    input  logic                             i_stvec_mode,
    input  logic [PC_WIDTH-1:0]              i_mepc,
    input  logic [PC_WIDTH-1:0]              i_sepc,
    output logic                             o_to_s,
    output logic [PC_WIDTH-1:0]              o_trap_pc,
    output logic [PC_WIDTH-1:0]              o_mret_pc,
    output logic [PC_WIDTH-1:0]              o_sret_pc
);

    logic                w_deleg_bit;
    logic                w_vectored;
    logic [PC_WIDTH-1:0] w_base;
    logic [PC_WIDTH-1:0] w_offset;

    assign w_deleg_bit = i_interrupt ? i_mideleg[i_cause] : i_medeleg[i_cause];
    assign o_to_s      = (i_priv != PRIV_M) && w_deleg_bit;

    always_comb begin
        w_base     = {i_mtvec_base, 2'b00};
        w_vectored = i_mtvec_mode & i_interrupt;
        if (o_to_s) begin
            w_base     = {i_stvec_base, 2'b00};
            w_vectored = i_stvec_mode & i_interrupt;
        end
    end

    // Vector offset is 4*cause; the sum wraps in PC_WIDTH.
    assign w_offset  = PC_WIDTH'({i_cause, 2'b00});
    assign o_trap_pc = w_vectored ? (w_base + w_offset) : w_base;
    assign o_mret_pc = i_mepc;
    assign o_sret_pc = i_sepc;

endmodule

// File: rtl/trap_ctrl.sv
// Commit-stage trap consumer: owns the M/S trap CSRs and privilege mode,
// issues redirects to fetch over valid/ready and sequences WFI sleep.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN                  = 64,
    parameter int PC_WIDTH              = 39,
    parameter int EXCEPTION_CAUSE_WIDTH = 4,
    parameter int CSR_ADDR_WIDTH        = 12
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             global_trap_i,
    input  logic                             global_mret_i,
    input  logic                             global_sret_i,
    input  logic                             global_wfi_i,
    input  logic [PC_WIDTH-1:0]              csr_pc_i,
    input  logic [EXCEPTION_CAUSE_WIDTH-1:0] csr_ecause_i,
    input  logic [XLEN-1:0]                  csr_etval_i,
    input  logic                             interrupt_i,
    input  logic                             irq_pending_i,
    input  logic                             csr_wr_en_i,
    input  logic [CSR_ADDR_WIDTH-1:0]        csr_addr_i,
    input  logic [XLEN-1:0]                  csr_wdata_i,
    output logic [XLEN-1:0]                  csr_rdata_o,
    output logic                             redirect_valid_o,
    output logic [PC_WIDTH-1:0]              redirect_pc_o,
    input  logic                             redirect_ready_i,
    output logic                             wfi_stall_o,
    output logic [1:0]                       priv_mode_o
);

    localparam logic [XLEN-1:0] EPC_MASK = ~XLEN'(2'b11);

    state_e              r_state;
    state_e              w_state_nxt;
    priv_e               r_priv;
    logic                r_mie, r_mpie, r_sie, r_spie, r_spp;
    logic [1:0]          r_mpp;
    logic [XLEN-1:0]     r_mepc, r_sepc, r_mcause, r_scause, r_mtval, r_stval;
    logic [XLEN-1:0]     r_mtvec, r_stvec, r_medeleg, r_mideleg;
    logic [PC_WIDTH-1:0] r_resume_pc;
    logic [PC_WIDTH-1:0] r_redirect_pc;

    logic                w_take_trap, w_take_mret, w_take_sret, w_take_wfi, w_wake;
    logic                w_load_redirect;
    logic [PC_WIDTH-1:0] w_redirect_nxt;
    logic                w_to_s;
    logic [PC_WIDTH-1:0] w_trap_pc, w_mret_pc, w_sret_pc;
    logic [XLEN-1:0]     w_cause_val;
    logic [XLEN-1:0]     w_trap_epc;
    logic [XLEN-1:0]     w_mstatus;

    // One event per cycle: trap > mret > sret > wfi. Only a trap or a pending
    // interrupt leaves WFI; everything arriving in REDIRECT is dropped.
    assign w_take_trap = global_trap_i && (r_state == ST_IDLE || r_state == ST_WFI);
    assign w_take_mret = global_mret_i && !global_trap_i && (r_state == ST_IDLE);
    assign w_take_sret = global_sret_i && !global_trap_i && !global_mret_i
                         && (r_state == ST_IDLE);
    assign w_take_wfi  = global_wfi_i && !global_trap_i && !global_mret_i
                         && !global_sret_i && (r_state == ST_IDLE);
    assign w_wake      = (r_state == ST_WFI) && irq_pending_i && !global_trap_i;

    trap_target_calc #(
        .XLEN                  (XLEN),
        .PC_WIDTH              (PC_WIDTH),
        .EXCEPTION_CAUSE_WIDTH (EXCEPTION_CAUSE_WIDTH)
    ) u_target (
        .i_priv       (r_priv),
        .i_interrupt  (interrupt_i),
        .i_cause      (csr_ecause_i),
        .i_medeleg    (r_medeleg),
        .i_mideleg    (r_mideleg),
        .i_mtvec_base (r_mtvec[PC_WIDTH-1:2]),
        .i_mtvec_mode (r_mtvec[0]),
        .i_stvec_base (r_stvec[PC_WIDTH-1:2]),
        .i_stvec_mode (r_stvec[0]),
        .i_mepc       (r_mepc[PC_WIDTH-1:0]),
        .i_sepc       (r_sepc[PC_WIDTH-1:0]),
        .o_to_s       (w_to_s),
        .o_trap_pc    (w_trap_pc),
        .o_mret_pc    (w_mret_pc),
        .o_sret_pc    (w_sret_pc)
    );

    always_comb begin
        w_cause_val                              = '0;
        w_cause_val[XLEN-1]                      = interrupt_i;
        w_cause_val[EXCEPTION_CAUSE_WIDTH-1:0]   = csr_ecause_i;
    end

    assign w_trap_epc = XLEN'(csr_pc_i) & EPC_MASK;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_take_trap || w_take_mret || w_take_sret)
                    w_state_nxt = ST_REDIRECT;
                else if (w_take_wfi)
                    w_state_nxt = ST_WFI;
            end
            ST_REDIRECT: begin
                if (redirect_ready_i)
                    w_state_nxt = ST_IDLE;
            end
            ST_WFI: begin
                if (w_take_trap || w_wake)
                    w_state_nxt = ST_REDIRECT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load_redirect = w_take_trap || w_take_mret || w_take_sret || w_wake;
        w_redirect_nxt  = r_resume_pc;
        if (w_take_trap)
            w_redirect_nxt = w_trap_pc;
        else if (w_take_mret)
            w_redirect_nxt = w_mret_pc;
        else if (w_take_sret)
            w_redirect_nxt = w_sret_pc;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_redirect_pc <= '0;
        else if (w_load_redirect)
            r_redirect_pc <= w_redirect_nxt;
    end

    assign redirect_valid_o = (r_state == ST_REDIRECT);
    assign wfi_stall_o      = (r_state == ST_WFI);
    assign redirect_pc_o    = r_redirect_pc;
    assign priv_mode_o      = r_priv;

    // Software write first, hardware event second: the event's fields win and
    // every field it leaves alone keeps the software value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_priv      <= PRIV_M;
            r_mie       <= 1'b0;
            r_mpie      <= 1'b0;
            r_sie       <= 1'b0;
            r_spie      <= 1'b0;
            r_spp       <= 1'b0;
            r_mpp       <= PRIV_U;
            r_mepc      <= '0;
            r_sepc      <= '0;
            r_mcause    <= '0;
            r_scause    <= '0;
            r_mtval     <= '0;
            r_stval     <= '0;
            r_mtvec     <= '0;
            r_stvec     <= '0;
            r_medeleg   <= '0;
            r_mideleg   <= '0;
            r_resume_pc <= '0;
        end else begin
            if (csr_wr_en_i) begin
                case (csr_addr_i)
                    CSR_ADDR_WIDTH'(CSR_MSTATUS): begin
                        r_mie  <= csr_wdata_i[MSTATUS_MIE];
                        r_mpie <= csr_wdata_i[MSTATUS_MPIE];
                        r_sie  <= csr_wdata_i[MSTATUS_SIE];
                        r_spie <= csr_wdata_i[MSTATUS_SPIE];
                        r_spp  <= csr_wdata_i[MSTATUS_SPP];
                        r_mpp  <= legal_mpp(csr_wdata_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
                    end
                    CSR_ADDR_WIDTH'(CSR_SSTATUS): begin
                        r_sie  <= csr_wdata_i[MSTATUS_SIE];
                        r_spie <= csr_wdata_i[MSTATUS_SPIE];
                        r_spp  <= csr_wdata_i[MSTATUS_SPP];
                    end
                    CSR_ADDR_WIDTH'(CSR_MEDELEG): r_medeleg <= csr_wdata_i;
                    CSR_ADDR_WIDTH'(CSR_MIDELEG): r_mideleg <= csr_wdata_i;
                    CSR_ADDR_WIDTH'(CSR_MTVEC):   r_mtvec   <= csr_wdata_i;
                    CSR_ADDR_WIDTH'(CSR_MEPC):    r_mepc    <= csr_wdata_i & EPC_MASK;
                    CSR_ADDR_WIDTH'(CSR_MCAUSE):  r_mcause  <= csr_wdata_i;
                    CSR_ADDR_WIDTH'(CSR_MTVAL):   r_mtval   <= csr_wdata_i;
                    CSR_ADDR_WIDTH'(CSR_STVEC):   r_stvec   <= csr_wdata_i;
                    CSR_ADDR_WIDTH'(CSR_SEPC):    r_sepc    <= csr_wdata_i & EPC_MASK;
                    CSR_ADDR_WIDTH'(CSR_SCAUSE):  r_scause  <= csr_wdata_i;
                    CSR_ADDR_WIDTH'(CSR_STVAL):   r_stval   <= csr_wdata_i;
                    default: ;
                endcase
            end

            if (w_take_trap) begin
                if (w_to_s) begin
                    r_sepc   <= w_trap_epc;
                    r_scause <= w_cause_val;
                    r_stval  <= csr_etval_i;
                    r_spie   <= r_sie;
                    r_sie    <= 1'b0;
                    r_spp    <= r_priv[0];
                    r_priv   <= PRIV_S;
                end else begin
                    r_mepc   <= w_trap_epc;
                    r_mcause <= w_cause_val;
                    r_mtval  <= csr_etval_i;
                    r_mpie   <= r_mie;
                    r_mie    <= 1'b0;
                    r_mpp    <= r_priv;
                    r_priv   <= PRIV_M;
                end
            end else if (w_take_mret) begin
                r_priv <= legal_mpp(r_mpp);
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
                r_mpp  <= PRIV_U;
            end else if (w_take_sret) begin
                r_priv <= priv_e'({1'b0, r_spp});
                r_sie  <= r_spie;
                r_spie <= 1'b1;
                r_spp  <= 1'b0;
            end

            if (w_take_wfi)
                r_resume_pc <= csr_pc_i;
        end
    end

    always_comb begin
        w_mstatus                                = '0;
        w_mstatus[MSTATUS_SIE]                   = r_sie;
        w_mstatus[MSTATUS_MIE]                   = r_mie;
        w_mstatus[MSTATUS_SPIE]                  = r_spie;
        w_mstatus[MSTATUS_MPIE]                  = r_mpie;
        w_mstatus[MSTATUS_SPP]                   = r_spp;
        w_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = r_mpp;
    end

    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_i)
            CSR_ADDR_WIDTH'(CSR_MSTATUS): csr_rdata_o = w_mstatus;
            CSR_ADDR_WIDTH'(CSR_SSTATUS): csr_rdata_o = w_mstatus & XLEN'(SSTATUS_MASK);
            CSR_ADDR_WIDTH'(CSR_MEDELEG): csr_rdata_o = r_medeleg;
            CSR_ADDR_WIDTH'(CSR_MIDELEG): csr_rdata_o = r_mideleg;
            CSR_ADDR_WIDTH'(CSR_MTVEC):   csr_rdata_o = r_mtvec;
            CSR_ADDR_WIDTH'(CSR_MEPC):    csr_rdata_o = r_mepc;
            CSR_ADDR_WIDTH'(CSR_MCAUSE):  csr_rdata_o = r_mcause;
            CSR_ADDR_WIDTH'(CSR_MTVAL):   csr_rdata_o = r_mtval;
            CSR_ADDR_WIDTH'(CSR_STVEC):   csr_rdata_o = r_stvec;
            CSR_ADDR_WIDTH'(CSR_SEPC):    csr_rdata_o = r_sepc;
            CSR_ADDR_WIDTH'(CSR_SCAUSE):  csr_rdata_o = r_scause;
            CSR_ADDR_WIDTH'(CSR_STVAL):   csr_rdata_o = r_stval;
            default:                      csr_rdata_o = '0;
        endcase
    end

`ifndef SYNTHESIS
    // The pipeline is flushed while a redirect is outstanding, so no commit strobe may arrive.
    a_no_strobe_in_redirect: assert property (@(posedge clk) disable iff (!rstn)
        (r_state == ST_REDIRECT) |->
            !(global_trap_i || global_mret_i || global_sret_i || global_wfi_i));
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: trap entry, vectoring, delegation, xRET,
// WFI wake-up, same-cycle priority and asynchronous reset.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam int XLEN = 64;
    localparam int PCW  = 39;

    logic            clk = 1'b0;
    logic            rstn;
    logic            global_trap_i, global_mret_i, global_sret_i, global_wfi_i;
    logic [PCW-1:0]  csr_pc_i;
    logic [3:0]      csr_ecause_i;
    logic [XLEN-1:0] csr_etval_i;
    logic            interrupt_i, irq_pending_i;
    logic            csr_wr_en_i;
    logic [11:0]     csr_addr_i;
    logic [XLEN-1:0] csr_wdata_i;
    logic [XLEN-1:0] csr_rdata_o;
    logic            redirect_valid_o;
    logic [PCW-1:0]  redirect_pc_o;
    logic            redirect_ready_i;
    logic            wfi_stall_o;
    logic [1:0]      priv_mode_o;

    int n_tests = 0;
    int n_fail  = 0;

    trap_ctrl #(
        .XLEN(XLEN), .PC_WIDTH(PCW), .EXCEPTION_CAUSE_WIDTH(4), .CSR_ADDR_WIDTH(12)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .global_trap_i    (global_trap_i),
        .global_mret_i    (global_mret_i),
        .global_sret_i    (global_sret_i),
        .global_wfi_i     (global_wfi_i),
        .csr_pc_i         (csr_pc_i),
        .csr_ecause_i     (csr_ecause_i),
        .csr_etval_i      (csr_etval_i),
        .interrupt_i      (interrupt_i),
        .irq_pending_i    (irq_pending_i),
        .csr_wr_en_i      (csr_wr_en_i),
        .csr_addr_i       (csr_addr_i),
        .csr_wdata_i      (csr_wdata_i),
        .csr_rdata_o      (csr_rdata_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .wfi_stall_o      (wfi_stall_o),
        .priv_mode_o      (priv_mode_o)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_csr(input string tag, input logic [11:0] addr, input logic [63:0] exp);
        csr_addr_i = addr;
        #1;
        chk_eq(tag, csr_rdata_o, exp);
    endtask

    task automatic wr_csr(input logic [11:0] addr, input logic [63:0] data);
        csr_wr_en_i = 1'b1;
        csr_addr_i  = addr;
        csr_wdata_i = data;
        tick();
        csr_wr_en_i = 1'b0;
    endtask

    task automatic accept();
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;
    endtask

    task automatic do_trap(input logic irq, input logic [3:0] cause,
                           input logic [PCW-1:0] pc, input logic [63:0] tval);
        global_trap_i = 1'b1;
        interrupt_i   = irq;
        csr_ecause_i  = cause;
        csr_pc_i      = pc;
        csr_etval_i   = tval;
        tick();
        global_trap_i = 1'b0;
        interrupt_i   = 1'b0;
    endtask

    task automatic do_mret();
        global_mret_i = 1'b1;
        tick();
        global_mret_i = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        {global_trap_i, global_mret_i, global_sret_i, global_wfi_i} = '0;
        csr_pc_i = '0; csr_ecause_i = '0; csr_etval_i = '0;
        interrupt_i = 1'b0; irq_pending_i = 1'b0;
        csr_wr_en_i = 1'b0; csr_addr_i = '0; csr_wdata_i = '0;
        redirect_ready_i = 1'b0;
        repeat (2) tick();
        chk_eq("rst_priv", 64'(priv_mode_o), 64'd3);
        chk_eq("rst_valid", 64'(redirect_valid_o), 64'd0);
        chk_eq("rst_stall", 64'(wfi_stall_o), 64'd0);
        chk_eq("rst_pc", 64'(redirect_pc_o), 64'd0);
        chk_csr("rst_mstatus", CSR_MSTATUS, 64'h0);
        rstn = 1'b1;
        tick();

        // Enter U mode via mret (MPP=U from reset).
        wr_csr(CSR_MTVEC, 64'h8000);
        wr_csr(CSR_MEPC, 64'h500);
        do_mret();
        chk_eq("mret_u_priv", 64'(priv_mode_o), 64'd0);
        chk_eq("mret_u_valid", 64'(redirect_valid_o), 64'd1);
        chk_eq("mret_u_pc", 64'(redirect_pc_o), 64'h500);
        chk_csr("mret_u_mstatus", CSR_MSTATUS, 64'h80);
        accept();
        chk_eq("accept_valid", 64'(redirect_valid_o), 64'd0);

        // 1: U-mode exception to M.
        do_trap(1'b0, 4'd2, 39'h1000, 64'hdead);
        chk_eq("t1_valid", 64'(redirect_valid_o), 64'd1);
        chk_eq("t1_pc", 64'(redirect_pc_o), 64'h8000);
        chk_eq("t1_priv", 64'(priv_mode_o), 64'd3);
        chk_csr("t1_mepc", CSR_MEPC, 64'h1000);
        chk_csr("t1_mcause", CSR_MCAUSE, 64'd2);
        chk_csr("t1_mtval", CSR_MTVAL, 64'hdead);
        chk_csr("t1_mstatus", CSR_MSTATUS, 64'h0);
        accept();

        // 2: vectored interrupt.
        wr_csr(CSR_MTVEC, 64'h8001);
        chk_csr("t2_mtvec", CSR_MTVEC, 64'h8001);
        do_trap(1'b1, 4'd7, 39'h1100, 64'h0);
        chk_eq("t2_pc", 64'(redirect_pc_o), 64'h801C);
        chk_csr("t2_mcause", CSR_MCAUSE, 64'h8000_0000_0000_0007);
        accept();

        // 3: delegated exception from S.
        wr_csr(CSR_MSTATUS, 64'h800);
        wr_csr(CSR_MEPC, 64'h600);
        do_mret();
        chk_eq("t3_enter_s", 64'(priv_mode_o), 64'd1);
        accept();
        wr_csr(CSR_MEDELEG, 64'h100);
        wr_csr(CSR_STVEC, 64'h9000);
        do_trap(1'b0, 4'd8, 39'h1200, 64'h55);
        chk_eq("t3_priv", 64'(priv_mode_o), 64'd1);
        chk_eq("t3_pc", 64'(redirect_pc_o), 64'h9000);
        chk_csr("t3_sepc", CSR_SEPC, 64'h1200);
        chk_csr("t3_scause", CSR_SCAUSE, 64'd8);
        chk_csr("t3_stval", CSR_STVAL, 64'h55);
        chk_csr("t3_sstatus", CSR_SSTATUS, 64'h100);
        chk_csr("t3_mepc_keep", CSR_MEPC, 64'h600);
        accept();

        // 4: mret to S with back-pressure.
        wr_csr(CSR_MSTATUS, 64'h880);
        wr_csr(CSR_MEPC, 64'h2007);
        chk_csr("t4_mepc_lowbits", CSR_MEPC, 64'h2004);
        do_mret();
        chk_eq("t4_priv", 64'(priv_mode_o), 64'd1);
        chk_csr("t4_mstatus", CSR_MSTATUS, 64'h88);
        for (int i = 0; i < 3; i++) begin
            chk_eq("t4_hold_valid", 64'(redirect_valid_o), 64'd1);
            chk_eq("t4_hold_pc", 64'(redirect_pc_o), 64'h2004);
            tick();
        end
        chk_eq("t4_valid_before_ready", 64'(redirect_valid_o), 64'd1);
        accept();
        chk_eq("t4_valid_after", 64'(redirect_valid_o), 64'd0);

        // 5: WFI sleep and wake.
        global_wfi_i = 1'b1;
        csr_pc_i     = 39'h3004;
        tick();
        global_wfi_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_eq("t5_stall", 64'(wfi_stall_o), 64'd1);
            chk_eq("t5_no_valid", 64'(redirect_valid_o), 64'd0);
            if (i < 4) tick();
        end
        irq_pending_i = 1'b1;
        tick();
        irq_pending_i = 1'b0;
        chk_eq("t5_wake_valid", 64'(redirect_valid_o), 64'd1);
        chk_eq("t5_wake_pc", 64'(redirect_pc_o), 64'h3004);
        chk_eq("t5_wake_stall", 64'(wfi_stall_o), 64'd0);
        accept();

        // 6: trap + mret + CSR write to mepc in one cycle.
        global_mret_i = 1'b1;
        csr_wr_en_i   = 1'b1;
        csr_addr_i    = CSR_MEPC;
        csr_wdata_i   = 64'h7777_0000;
        do_trap(1'b0, 4'd2, 39'h4000, 64'h0);
        global_mret_i = 1'b0;
        csr_wr_en_i   = 1'b0;
        chk_eq("t6_priv", 64'(priv_mode_o), 64'd3);
        chk_eq("t6_pc", 64'(redirect_pc_o), 64'h8000);
        chk_csr("t6_mepc", CSR_MEPC, 64'h4000);
        chk_csr("t6_mcause", CSR_MCAUSE, 64'd2);
        chk_csr("t6_mstatus", CSR_MSTATUS, 64'h880);
        chk_csr("unmapped", 12'h7c0, 64'h0);

        // Asynchronous reset while a redirect is outstanding.
        #2 rstn = 1'b0;
        #1;
        chk_eq("arst_valid", 64'(redirect_valid_o), 64'd0);
        chk_eq("arst_priv", 64'(priv_mode_o), 64'd3);
        chk_eq("arst_pc", 64'(redirect_pc_o), 64'd0);
        chk_csr("arst_mepc", CSR_MEPC, 64'h0);
        tick();
        rstn = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
